// File: rtl/phase_pkg.sv
// Shared types and helpers for the phase_match front end.
package phase_pkg;

  localparam int DEF_BEAT_SIZE  = 8;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    FLUSH
  } arb_state_t;

  typedef logic [DEF_BEAT_SIZE-1:0][DEF_DATA_WIDTH-1:0] beat_t;

  function automatic int row_beats(input int row_size, input int beat_size);
    return row_size / beat_size;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer carrying data, last and user.
// s_ready comes straight from a register, so m_ready never reaches upstream combinationally.
module axis_skid_buf #(
  parameter int DATA_W = 128,
  parameter int USER_W = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [USER_W-1:0] s_user,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [USER_W-1:0] m_user,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int W = DATA_W + USER_W + 1;

  logic [W-1:0] out_reg;
  logic [W-1:0] skid_reg;
  logic         out_valid_reg;
  logic         skid_valid_reg;
  logic         s_fire;
  logic         out_free;

  assign s_ready  = !skid_valid_reg;
  assign s_fire   = s_valid && s_ready;
  assign out_free = m_ready || !out_valid_reg;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      // Output register drains: refill from the skid entry first, else from the input.
      if (skid_valid_reg) begin
        out_reg        <= skid_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= s_fire;
        if (s_fire) begin
          out_reg <= {s_data, s_last, s_user};
        end
      end
    end else if (s_fire) begin
      skid_reg       <= {s_data, s_last, s_user};
      skid_valid_reg <= 1'b1;
    end
  end

  assign {m_data, m_last, m_user} = out_reg;
  assign m_valid                  = out_valid_reg;

endmodule

// File: rtl/phase_row_arbiter.sv
// Row-granular round-robin arbiter feeding phase_match from two AXI-Stream sources,
// enforcing a fixed row length and tagging each beat with its source id.
module phase_row_arbiter
  import phase_pkg::*;
#(
  parameter int ROW_SIZE   = 1280,
  parameter int BEAT_SIZE  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                            s0_axis_tvalid,
  output logic                            s0_axis_tready,
  input  logic                            s0_axis_tlast,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                            s1_axis_tvalid,
  output logic                            s1_axis_tready,
  input  logic                            s1_axis_tlast,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            err_short,
  output logic                            err_long,
  output logic [15:0]                     rows_done
);

  localparam int ROW_BEATS = row_beats(ROW_SIZE, BEAT_SIZE);
  localparam int CNT_WIDTH = $clog2(ROW_BEATS);
  localparam int W         = BEAT_SIZE * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(ROW_BEATS - 1);

  arb_state_t           state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic                 last_grant_reg, last_grant_next;
  logic [CNT_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
  logic                 err_short_reg, err_short_next;
  logic                 err_long_reg, err_long_next;
  logic [15:0]          rows_done_reg, rows_done_next;

  logic [1:0]   src_valid;
  logic [1:0]   src_last;
  logic [1:0]   src_ready;
  logic [W-1:0] src_data [2];
  logic [W-1:0] sel_data;
  logic         sel_valid;
  logic         sel_last;
  logic         sel_fire;
  logic         at_last;
  logic         slice_valid;
  logic         slice_ready;

  assign src_valid   = {s1_axis_tvalid, s0_axis_tvalid};
  assign src_last    = {s1_axis_tlast, s0_axis_tlast};
  assign src_data[0] = s0_axis_tdata;
  assign src_data[1] = s1_axis_tdata;

  // Only the granted source sees ready: throttled by the slice in FWD, free-running in FLUSH.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign src_ready[gi] = (grant_reg == 1'(gi)) &&
                             (((state_reg == FWD) && slice_ready) || (state_reg == FLUSH));
    end
  endgenerate

  assign s0_axis_tready = src_ready[0];
  assign s1_axis_tready = src_ready[1];

  assign sel_valid   = src_valid[grant_reg];
  assign sel_last    = src_last[grant_reg];
  assign sel_data    = src_data[grant_reg];
  assign sel_fire    = sel_valid && src_ready[grant_reg];
  assign at_last     = (beat_cnt_reg == LAST_BEAT);
  assign slice_valid = (state_reg == FWD) && sel_valid;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    err_short_next  = 1'b0;
    err_long_next   = 1'b0;
    rows_done_next  = rows_done_reg;
    case (state_reg)
      IDLE: begin
        if (|src_valid) begin
          grant_next      = (&src_valid) ? !last_grant_reg : src_valid[1];
          last_grant_next = grant_next;
          state_next      = FWD;
        end
      end
      FWD: begin
        if (sel_fire) begin
          if (sel_last || at_last) begin
            beat_cnt_next  = '0;
            rows_done_next = rows_done_reg + 16'd1;
            err_short_next = !at_last;
            err_long_next  = !sel_last;
            state_next     = sel_last ? IDLE : FLUSH;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (sel_fire && sel_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      beat_cnt_reg   <= '0;
      err_short_reg  <= 1'b0;
      err_long_reg   <= 1'b0;
      rows_done_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      err_short_reg  <= err_short_next;
      err_long_reg   <= err_long_next;
      rows_done_reg  <= rows_done_next;
    end
  end

  assign err_short = err_short_reg;
  assign err_long  = err_long_reg;
  assign rows_done = rows_done_reg;

  axis_skid_buf #(
    .DATA_W (W),
    .USER_W (1)
  ) u_slice (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_data  (sel_data),
    .s_last  (sel_last || at_last),
    .s_user  (grant_reg),
    .s_valid (slice_valid),
    .s_ready (slice_ready),
    .m_data  (m_axis_tdata),
    .m_last  (m_axis_tlast),
    .m_user  (m_axis_tuser),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

endmodule
